tlul_host_adapter: RTL and testbench



---
 rtl/tlul_host_adapter_pkg.sv | 18 +
 rtl/tlul_pkg.sv | 43 ++++
 rtl/tlul_host_adapter.sv | 162 ++++++++++++++++
 tb/tb_tlul_host_adapter.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/tlul_host_adapter_pkg.sv
// Adapter-local types: FSM state encoding and the captured host request.
package tlul_host_adapter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        A_SEND = 2'd1,
        D_WAIT = 2'd2,
        DRAIN  = 2'd3
    } state_e;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } req_fields_t;

endpackage

// File: rtl/tlul_pkg.sv
// TL-UL channel types, opcodes and default user bits shared by hosts and devices.
package tlul_pkg;

    typedef enum logic [2:0] {
        PutFullData    = 3'h0,
        PutPartialData = 3'h1,
        Get            = 3'h4
    } tl_a_op_e;

    typedef enum logic [2:0] {
        AccessAck     = 3'h0,
        AccessAckData = 3'h1
    } tl_d_op_e;

    typedef logic [6:0] tl_a_user_t;
    localparam tl_a_user_t TL_A_USER_DEFAULT = 7'h00;

    typedef struct packed {
        logic       a_valid;
        tl_a_op_e   a_opcode;
        logic [2:0] a_param;
        logic [1:0] a_size;
        logic [7:0] a_source;
        logic [31:0] a_address;
        logic [3:0] a_mask;
        logic [31:0] a_data;
        tl_a_user_t a_user;
        logic       d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic       d_valid;
        tl_d_op_e   d_opcode;
        logic [2:0] d_param;
        logic [1:0] d_size;
        logic [7:0] d_source;
        logic       d_sink;
        logic [31:0] d_data;
        logic       d_error;
        logic       a_ready;
    } tl_d2h_t;

endpackage

// File: rtl/tlul_host_adapter.sv
// Single-outstanding TL-UL host adapter: req/gnt/rvalid host bus in, TL-UL A/D out.
//
// Handshakes: a TL-UL beat transfers on a clock edge where valid and ready are
// both high; a_valid and all A fields stay stable from assertion until that edge.
// On the host side gnt_o and rvalid_o are single-cycle pulses, req_i is held
// until gnt_o, and rdata_o/err_o are only meaningful while rvalid_o is high.
module tlul_host_adapter
    import tlul_pkg::*;
    import tlul_host_adapter_pkg::*;
#(
    parameter int unsigned TimeoutCycles = 1024,
    parameter logic [7:0]  SourceBase    = 8'h00
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  be_i,
    output logic        gnt_o,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        err_o,
    output logic        busy_o,
    output tl_h2d_t     tl_o,
    input  tl_d2h_t     tl_i
);

    state_e      r_state;
    state_e      w_state_nxt;
    req_fields_t r_fields;
    logic [7:0]  r_source;
    logic [31:0] r_tcnt;
    logic        r_rvalid;
    logic        r_err;
    logic [31:0] r_rdata;

    logic w_gnt;
    logic w_a_valid;
    logic w_d_ready;
    logic w_resp;
    logic w_timeout;
    logic w_limit;
    logic w_chk_err;
    logic w_unused_tl;

    // Response fields this adapter does not interpret.
    assign w_unused_tl = ^{tl_i.d_param, tl_i.d_size, tl_i.d_sink};

    // Error when the device flags one, answers the wrong source, or uses the wrong ack kind.
    function automatic logic resp_err(input logic we, input logic [7:0] issued,
                                      input tl_d_op_e op, input logic [7:0] src,
                                      input logic d_error);
        logic bad_op;
        bad_op = we ? (op != AccessAck) : (op != AccessAckData);
        return d_error | (src != issued) | bad_op;
    endfunction

    // Limit reached on the cycle that would bring the wait count to TimeoutCycles.
    assign w_limit   = (TimeoutCycles != 0) && (r_tcnt == TimeoutCycles - 1);
    assign w_chk_err = resp_err(r_fields.we, r_source, tl_i.d_opcode,
                                tl_i.d_source, tl_i.d_error);

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next state and handshake strobes; a d_valid on the limit cycle beats the timeout.
    always_comb begin
        w_state_nxt = r_state;
        w_gnt       = 1'b0;
        w_a_valid   = 1'b0;
        w_d_ready   = 1'b0;
        w_resp      = 1'b0;
        w_timeout   = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_gnt = req_i;
                if (req_i) w_state_nxt = A_SEND;
            end
            A_SEND: begin
                w_a_valid = 1'b1;
                if (tl_i.a_ready) w_state_nxt = D_WAIT;
            end
            D_WAIT: begin
                w_d_ready = 1'b1;
                if (tl_i.d_valid) begin
                    w_resp      = 1'b1;
                    w_state_nxt = IDLE;
                end else if (w_limit) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                w_d_ready = 1'b1;
                if (tl_i.d_valid) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Request capture, source tagging, wait counter and registered response.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_fields <= '0;
            r_source <= SourceBase;
            r_tcnt   <= '0;
            r_rvalid <= 1'b0;
            r_err    <= 1'b0;
            r_rdata  <= '0;
        end else begin
            r_rvalid <= w_resp | w_timeout;
            if (w_gnt) begin
                r_fields.we    <= we_i;
                r_fields.addr  <= {addr_i[31:2], 2'b00};
                r_fields.wdata <= wdata_i;
                r_fields.be    <= be_i;
            end
            if (w_a_valid && tl_i.a_ready) begin
                r_tcnt <= '0;
            end else if (r_state == D_WAIT && !tl_i.d_valid) begin
                r_tcnt <= r_tcnt + 32'd1;
            end
            if (w_resp) begin
                r_err    <= w_chk_err;
                r_rdata  <= (!r_fields.we && !w_chk_err) ? tl_i.d_data : 32'h0;
                r_source <= r_source + 8'd1;
            end else if (w_timeout) begin
                r_err    <= 1'b1;
                r_rdata  <= 32'h0;
                r_source <= r_source + 8'd1;
            end
        end
    end

    // A-channel encoding from the captured request; d_ready while a response is awaited.
    always_comb begin
        tl_o           = '0;
        tl_o.a_valid   = w_a_valid;
        tl_o.a_opcode  = !r_fields.we ? Get :
                         (r_fields.be == 4'hF) ? PutFullData : PutPartialData;
        tl_o.a_param   = 3'd0;
        tl_o.a_size    = 2'd2;
        tl_o.a_source  = r_source;
        tl_o.a_address = r_fields.addr;
        tl_o.a_mask    = r_fields.we ? r_fields.be : 4'hF;
        tl_o.a_data    = r_fields.we ? r_fields.wdata : 32'h0;
        tl_o.a_user    = TL_A_USER_DEFAULT;
        tl_o.d_ready   = w_d_ready;
    end

    assign gnt_o    = w_gnt;
    assign rvalid_o = r_rvalid;
    assign rdata_o  = r_rdata;
    assign err_o    = r_err;
    assign busy_o   = (r_state != IDLE);

endmodule

// File: tb/tb_tlul_host_adapter.sv
// Bench for tlul_host_adapter: directed cases, a mid-transaction reset and a
// randomized run checked against a transaction-level model of the adapter.
module tb_tlul_host_adapter;
    import tlul_pkg::*;

    localparam int TO = 8;

    logic        clk;
    logic        rst_i;
    logic        req_i;
    logic        we_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic [3:0]  be_i;
    logic        gnt_o;
    logic        rvalid_o;
    logic [31:0] rdata_o;
    logic        err_o;
    logic        busy_o;
    tl_h2d_t     tl_o;
    tl_d2h_t     tl_i;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          n_gnt_seen = 0;
    int          n_gnt_exp  = 0;
    logic [7:0]  exp_src;
    logic        rv_due = 1'b0;
    logic [32:0] exp_q[$];

    tlul_host_adapter #(
        .TimeoutCycles(TO),
        .SourceBase   (8'h00)
    ) dut (
        .clk_i   (clk),
        .rst_i   (rst_i),
        .req_i   (req_i),
        .we_i    (we_i),
        .addr_i  (addr_i),
        .wdata_i (wdata_i),
        .be_i    (be_i),
        .gnt_o   (gnt_o),
        .rvalid_o(rvalid_o),
        .rdata_o (rdata_o),
        .err_o   (err_o),
        .busy_o  (busy_o),
        .tl_o    (tl_o),
        .tl_i    (tl_i)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
        else n_pass++;
    endtask

    // scoreboard: rvalid must appear exactly when due, carrying the queued response
    always @(negedge clk) begin
        if (!rst_i) begin
            check("rvalid_timing", rvalid_o, rv_due);
            if (rvalid_o && exp_q.size() != 0) check("resp", {err_o, rdata_o}, exp_q.pop_front());
            if (gnt_o) n_gnt_seen++;
            rv_due = 1'b0;
        end
    end

    task automatic drive_resp(input tl_d_op_e op, input logic [7:0] src,
                              input logic [31:0] data, input logic derr);
        tl_i.d_valid  = 1'b1;
        tl_i.d_opcode = op;
        tl_i.d_source = src;
        tl_i.d_data   = data;
        tl_i.d_error  = derr;
        tl_i.d_param  = 3'($urandom_range(0, 7));
        tl_i.d_size   = 2'd2;
    endtask

    // kind: 0 good, 1 wrong source, 2 wrong opcode, 3 d_error, 4 no response (timeout)
    task automatic do_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, input int a_dly, input bit hold_req,
                          input int kind, input int d_dly, input logic [31:0] dev_data,
                          input logic [7:0] dev_src);
        tl_h2d_t    exp_a;
        tl_d_op_e   op;
        logic [7:0] src;
        logic       exp_err;
        exp_a           = '0;
        exp_a.a_valid   = 1'b1;
        exp_a.a_opcode  = !we ? Get : (be == 4'hF) ? PutFullData : PutPartialData;
        exp_a.a_size    = 2'd2;
        exp_a.a_source  = exp_src;
        exp_a.a_address = addr & 32'hFFFF_FFFC;
        exp_a.a_mask    = we ? be : 4'hF;
        exp_a.a_data    = we ? wdata : 32'h0;
        exp_a.a_user    = TL_A_USER_DEFAULT;

        @(posedge clk); #1;
        req_i = 1'b1; we_i = we; addr_i = addr; wdata_i = wdata; be_i = be;
        @(negedge clk);
        check("gnt", gnt_o, 1'b1);
        check("busy_idle", busy_o, 1'b0);
        n_gnt_exp++;
        @(posedge clk); #1;
        if (!hold_req) req_i = 1'b0;
        we_i = 1'($urandom); addr_i = $urandom; wdata_i = $urandom; be_i = 4'($urandom);
        for (int k = 0; k <= a_dly; k++) begin
            if (k == a_dly) begin
                tl_i.a_ready = 1'b1;
                req_i = 1'b0;
            end
            @(negedge clk);
            check("a_fields", tl_o, exp_a);
            check("gnt_asend", gnt_o, 1'b0);
            check("busy_asend", busy_o, 1'b1);
            @(posedge clk); #1;
        end
        tl_i.a_ready = 1'b0;

        if (kind == 4) begin
            for (int j = 0; j < TO; j++) begin
                @(negedge clk);
                check("d_ready_wait", tl_o.d_ready, 1'b1);
                check("busy_wait", busy_o, 1'b1);
                @(posedge clk); #1;
            end
            exp_q.push_back({1'b1, 32'h0});
            rv_due = 1'b1;
            exp_src++;
            for (int j = 0; j <= d_dly; j++) begin
                if (j == d_dly) drive_resp(AccessAckData, 8'($urandom), $urandom, 1'b0);
                @(negedge clk);
                check("busy_drain", busy_o, 1'b1);
                check("d_ready_drain", tl_o.d_ready, 1'b1);
                @(posedge clk); #1;
            end
            tl_i.d_valid = 1'b0;
            @(negedge clk);
            check("busy_after_drain", busy_o, 1'b0);
        end else begin
            op  = we ? AccessAck : AccessAckData;
            if (kind == 2) op = we ? AccessAckData : AccessAck;
            src = (kind == 1) ? dev_src : exp_src;
            exp_err = (kind == 3) || (src != exp_src) ||
                      (we ? (op != AccessAck) : (op != AccessAckData));
            for (int j = 0; j <= d_dly; j++) begin
                if (j == d_dly) drive_resp(op, src, dev_data, kind == 3);
                @(negedge clk);
                check("d_ready_wait", tl_o.d_ready, 1'b1);
                check("busy_wait", busy_o, 1'b1);
                @(posedge clk); #1;
            end
            tl_i.d_valid = 1'b0;
            exp_q.push_back({exp_err, (!we && !exp_err) ? dev_data : 32'h0});
            rv_due = 1'b1;
            exp_src++;
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_gnt"},    gnt_o, 1'b0);
        check({tag, "_rvalid"}, rvalid_o, 1'b0);
        check({tag, "_err"},    err_o, 1'b0);
        check({tag, "_busy"},   busy_o, 1'b0);
        check({tag, "_rdata"},  rdata_o, 32'h0);
        check({tag, "_a_valid"}, tl_o.a_valid, 1'b0);
        check({tag, "_d_ready"}, tl_o.d_ready, 1'b0);
    endtask

    initial begin
        int kind, r;
        rst_i = 1'b1; req_i = 1'b0; we_i = 1'b0; addr_i = '0; wdata_i = '0; be_i = '0;
        tl_i = '0;
        exp_src = 8'h00;
        #1;
        check_idle_outputs("reset");
        repeat (2) @(posedge clk);
        #1 rst_i = 1'b0;

        // directed
        do_txn(1'b1, 32'h104, 32'hDEAD_BEEF, 4'hF, 0, 1'b0, 0, 0, 32'h0, 8'h00);
        do_txn(1'b0, 32'h10B, 32'h0, 4'h0, 0, 1'b0, 0, 1, 32'h0000_000A, 8'h00);
        do_txn(1'b0, 32'h200, 32'h0, 4'h0, 1, 1'b0, 1, 0, 32'h1234_5678, 8'h05);
        do_txn(1'b1, 32'h300, 32'hCAFE_F00D, 4'b0011, 5, 1'b1, 0, 2, 32'h0, 8'h00);
        do_txn(1'b0, 32'h400, 32'h0, 4'h0, 0, 1'b0, 4, 3, 32'h0, 8'h00);
        do_txn(1'b0, 32'h404, 32'h0, 4'h0, 0, 1'b0, 0, TO - 1, 32'h0BAD_CAFE, 8'h00);
        do_txn(1'b1, 32'h408, 32'h1111_2222, 4'hF, 0, 1'b0, 2, 0, 32'h0, 8'h00);
        do_txn(1'b0, 32'h40C, 32'h0, 4'h0, 0, 1'b0, 3, 0, 32'h7777_7777, 8'h00);
        do_txn(1'b0, 32'h410, 32'h0, 4'h0, 0, 1'b0, 0, 0, 32'h5A5A_0001, 8'h00);

        // reset in D_WAIT aborts without a response
        @(posedge clk); #1;
        req_i = 1'b1; we_i = 1'b0; addr_i = 32'h20;
        @(negedge clk);
        n_gnt_exp++;
        @(posedge clk); #1;
        req_i = 1'b0; tl_i.a_ready = 1'b1;
        @(posedge clk); #1;
        tl_i.a_ready = 1'b0;
        @(negedge clk);
        check("busy_before_rst", busy_o, 1'b1);
        @(posedge clk); #3;
        rst_i = 1'b1;
        #1;
        check_idle_outputs("async_rst");
        exp_src = 8'h00;
        @(posedge clk); #1;
        rst_i = 1'b0;
        repeat (3) @(posedge clk);
        do_txn(1'b1, 32'h500, 32'hA5A5_5A5A, 4'hF, 0, 1'b0, 0, 0, 32'h0, 8'h00);

        // randomized; long enough to wrap the 8-bit source counter
        for (int t = 0; t < 270; t++) begin
            r = $urandom_range(0, 9);
            kind = (r <= 5) ? 0 : r - 5;
            do_txn(1'($urandom), $urandom, $urandom, 4'($urandom), $urandom_range(0, 3),
                   1'($urandom), kind, (kind == 4) ? $urandom_range(0, 3) : $urandom_range(0, TO - 1),
                   $urandom, exp_src ^ 8'($urandom_range(1, 255)));
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("gnt_count", n_gnt_seen, n_gnt_exp);
        check("sb_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
